// File: rtl/axis_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_fifo
// Brief    : Store-and-forward AXI4-Stream packet FIFO. A packet is presented
//            downstream only once its TLAST beat is stored; a packet longer
//            than DEPTH switches the FIFO to cut-through until its TLAST beat
//            drains, so the stream can never deadlock.
// Ports    : aclk, aresetn (sync, active-low)
//            s_axis_* : upstream AXI4-Stream slave (tvalid/tready/tdata/
//                       tkeep/tlast/tid/tdest/tuser)
//            m_axis_* : downstream AXI4-Stream master, same payload fields
//            level          : beats currently stored
//            pkt_count      : complete packets stored and not yet drained
//            oversize_count : cut-through fallbacks taken (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module axis_packet_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]      s_axis_tkeep,
    input  logic                         s_axis_tlast,
    input  logic [ID_WIDTH-1:0]          s_axis_tid,
    input  logic [DEST_WIDTH-1:0]        s_axis_tdest,
    input  logic [USER_WIDTH-1:0]        s_axis_tuser,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]      m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic [ID_WIDTH-1:0]          m_axis_tid,
    output logic [DEST_WIDTH-1:0]        m_axis_tdest,
    output logic [USER_WIDTH-1:0]        m_axis_tuser,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
    output logic [15:0]                  oversize_count
);

    localparam int c_keep_w = DATA_WIDTH / 8;
    localparam int c_ptr_w  = $clog2(DEPTH) + 1;
    localparam int c_idx_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEPTH + 1);
    localparam int c_ent_w  = DATA_WIDTH + c_keep_w + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_full_lv = c_cnt_w'(DEPTH);
    localparam logic [15:0]        c_ovf_max = 16'hFFFF;

    // Packet-gating FSM
    localparam logic [0:0] c_st_store = 1'b0;
    localparam logic [0:0] c_st_cut   = 1'b1;

    logic [c_ent_w-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_level;
    logic [c_cnt_w-1:0]    r_pkt_count;
    logic [15:0]           r_oversize_count;
    logic [0:0]            r_state;
    logic [0:0]            w_state_next;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_m_valid;
    logic                  w_cut;
    logic                  w_enter_cut;
    logic                  w_pkt_inc;
    logic                  w_pkt_dec;
    logic [c_ent_w-1:0]    w_wr_entry;
    logic [c_ent_w-1:0]    w_rd_entry;

    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [c_keep_w-1:0]   w_rd_keep;
    logic                  w_rd_last;
    logic [ID_WIDTH-1:0]   w_rd_id;
    logic [DEST_WIDTH-1:0] w_rd_dest;
    logic [USER_WIDTH-1:0] w_rd_user;

    // ------------------------------------------------------------------------
    // Status and handshakes
    // ------------------------------------------------------------------------
    assign w_full        = (r_level == c_full_lv);
    assign w_empty       = (r_level == '0);
    assign s_axis_tready = aresetn && !w_full;
    assign w_wr_en       = s_axis_tvalid && s_axis_tready;

    // Head beat is offered only when a whole packet is stored, or while an
    // oversize packet is being streamed through.
    assign w_m_valid     = aresetn && !w_empty && ((r_pkt_count != '0) || w_cut);
    assign w_rd_en       = w_m_valid && m_axis_tready;

    assign w_pkt_inc     = w_wr_en && s_axis_tlast;
    assign w_pkt_dec     = w_rd_en && w_rd_last;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    assign w_wr_entry = {s_axis_tdata, s_axis_tkeep, s_axis_tlast,
                         s_axis_tid, s_axis_tdest, s_axis_tuser};
    assign w_rd_entry = r_mem[r_rd_ptr[c_idx_w-1:0]];
    assign {w_rd_data, w_rd_keep, w_rd_last, w_rd_id, w_rd_dest, w_rd_user} = w_rd_entry;

    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_idx_w-1:0]] <= w_wr_entry;
        end
    end

    // Payload is forced to zero whenever no beat is being offered.
    assign m_axis_tvalid = w_m_valid;
    assign m_axis_tdata  = w_m_valid ? w_rd_data : '0;
    assign m_axis_tkeep  = w_m_valid ? w_rd_keep : '0;
    assign m_axis_tlast  = w_m_valid ? w_rd_last : 1'b0;
    assign m_axis_tid    = w_m_valid ? w_rd_id   : '0;
    assign m_axis_tdest  = w_m_valid ? w_rd_dest : '0;
    assign m_axis_tuser  = w_m_valid ? w_rd_user : '0;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= c_st_store;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // A full FIFO with no complete packet can only make progress by
    // streaming the partial packet out, so fall back to cut-through.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_store: begin
                if (w_full && (r_pkt_count == '0)) begin
                    w_state_next = c_st_cut;
                end
            end
            c_st_cut: begin
                if (w_rd_en && w_rd_last) begin
                    w_state_next = c_st_store;
                end
            end
            default: w_state_next = c_st_store;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_cut       = (r_state == c_st_cut);
        w_enter_cut = (r_state == c_st_store) && w_full && (r_pkt_count == '0);
    end

    // ------------------------------------------------------------------------
    // Pointers and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_level          <= '0;
            r_pkt_count      <= '0;
            r_oversize_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end

            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + c_cnt_one;
                2'b01:   r_level <= r_level - c_cnt_one;
                default: r_level <= r_level;
            endcase

            case ({w_pkt_inc, w_pkt_dec})
                2'b10:   r_pkt_count <= r_pkt_count + c_cnt_one;
                2'b01:   r_pkt_count <= r_pkt_count - c_cnt_one;
                default: r_pkt_count <= r_pkt_count;
            endcase

            if (w_enter_cut && (r_oversize_count != c_ovf_max)) begin
                r_oversize_count <= r_oversize_count + 16'd1;
            end
        end
    end

    assign level          = r_level;
    assign pkt_count      = r_pkt_count;
    assign oversize_count = r_oversize_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_packet_fifo
// Brief    : Self-checking bench for axis_packet_fifo. A queue-based
//            reference model tracks stored beats, complete packets and the
//            cut-through condition; a monitor compares the DUT every cycle
//            and scores every delivered beat against the model queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_packet_fifo;

    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int DSW   = 4;
    localparam int UW    = 32;
    localparam int DEPTH = 16;
    localparam int KW    = DW / 8;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [KW-1:0]  keep;
        logic           last;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
    } beat_t;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic [DW-1:0]  s_axis_tdata;
    logic [KW-1:0]  s_axis_tkeep;
    logic           s_axis_tlast;
    logic [IW-1:0]  s_axis_tid;
    logic [DSW-1:0] s_axis_tdest;
    logic [UW-1:0]  s_axis_tuser;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic [DW-1:0]  m_axis_tdata;
    logic [KW-1:0]  m_axis_tkeep;
    logic           m_axis_tlast;
    logic [IW-1:0]  m_axis_tid;
    logic [DSW-1:0] m_axis_tdest;
    logic [UW-1:0]  m_axis_tuser;
    logic [CW-1:0]  level;
    logic [CW-1:0]  pkt_count;
    logic [15:0]    oversize_count;

    always #5 aclk = ~aclk;

    axis_packet_fifo #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .DEST_WIDTH (DSW),
        .USER_WIDTH (UW),
        .DEPTH      (DEPTH)
    ) u_dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tid     (s_axis_tid),
        .s_axis_tdest   (s_axis_tdest),
        .s_axis_tuser   (s_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tid     (m_axis_tid),
        .m_axis_tdest   (m_axis_tdest),
        .m_axis_tuser   (m_axis_tuser),
        .level          (level),
        .pkt_count      (pkt_count),
        .oversize_count (oversize_count)
    );

    // Reference model: contents, complete packets, cut-through flag, events
    beat_t model_q[$];
    int    m_pkts    = 0;
    bit    m_cut     = 1'b0;
    int    m_ovf     = 0;

    int    n_cmp     = 0;
    int    n_err     = 0;
    int    n_rd      = 0;
    int    cycle     = 0;
    bit    mon_en    = 1'b0;
    int    sink_mode = 0;   // 0: hold off, 1: always ready, 2: random

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual=timeout required=completion (t=%0t)", name, $time);
    endfunction

    // ------------------------------------------------------------------------
    // Downstream sink: ready pattern applied at posedge+2
    // ------------------------------------------------------------------------
    initial begin : p_sink
        m_axis_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #2;
            case (sink_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Monitor / scoreboard: compares on the falling edge, then advances the
    // model to the state it must hold after the next rising edge.
    // ------------------------------------------------------------------------
    initial begin : p_monitor
        int    pre_size;
        int    pre_pkts;
        bit    wr;
        bit    rd;
        bit    rd_last;
        beat_t e;
        beat_t a;
        beat_t w;
        forever begin
            @(negedge aclk);
            cycle++;
            if (mon_en) begin
                chk("s_tready", s_axis_tready, aresetn && (model_q.size() < DEPTH));
                chk("m_tvalid", m_axis_tvalid,
                    aresetn && (model_q.size() != 0) && ((m_pkts != 0) || m_cut));
                chk("level", level, model_q.size());
                chk("pkt_count", pkt_count, m_pkts);
                chk("oversize_count", oversize_count, m_ovf);
                if (m_axis_tvalid !== 1'b1) begin
                    chk("idle_payload", |{m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                                          m_axis_tid, m_axis_tdest, m_axis_tuser}, 1'b0);
                end

                if (!aresetn) begin
                    model_q.delete();
                    m_pkts = 0;
                    m_cut  = 1'b0;
                    m_ovf  = 0;
                end else begin
                    pre_size = model_q.size();
                    pre_pkts = m_pkts;
                    wr       = s_axis_tvalid && s_axis_tready;
                    rd       = m_axis_tvalid && m_axis_tready;
                    rd_last  = 1'b0;
                    if (rd) begin
                        n_rd++;
                        a = {m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                             m_axis_tid, m_axis_tdest, m_axis_tuser};
                        if (model_q.size() == 0) begin
                            chk("unexpected_beat", a, 0);
                            n_err += (a === '0) ? 1 : 0;
                        end else begin
                            e = model_q.pop_front();
                            chk("beat", a, e);
                            rd_last = e.last;
                            if (e.last) m_pkts--;
                        end
                    end
                    if (wr) begin
                        w = {s_axis_tdata, s_axis_tkeep, s_axis_tlast,
                             s_axis_tid, s_axis_tdest, s_axis_tuser};
                        model_q.push_back(w);
                        if (w.last) m_pkts++;
                    end
                    if (!m_cut && (pre_size == DEPTH) && (pre_pkts == 0)) begin
                        m_cut = 1'b1;
                        if (m_ovf < 65535) m_ovf++;
                    end else if (m_cut && rd && rd_last) begin
                        m_cut = 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver helpers (called at posedge+1, return at posedge+1)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_sink(input int mode);
        sink_mode = mode;
        tick();
    endtask

    task automatic send_beat(input beat_t b);
        bit hs;
        int t;
        hs = 1'b0;
        t  = 0;
        s_axis_tvalid = 1'b1;
        {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser} = b;
        while (!hs && (t < 2000)) begin
            @(negedge aclk);
            hs = (s_axis_tready === 1'b1);
            t++;
            tick();
        end
        s_axis_tvalid = 1'b0;
        if (!hs) fail_now("send_timeout");
    endtask

    task automatic send_pkt(input int len, input int id, input int dest,
                            input int gap_max, input bit with_last);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.keep = KW'($urandom);
            b.last = with_last && (i == len - 1);
            b.id   = IW'(id);
            b.dest = DSW'(dest);
            b.user = $urandom;
            send_beat(b);
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int t;
        t = 0;
        while ((model_q.size() != 0) && (t < max_cyc)) begin
            tick();
            t++;
        end
        if (model_q.size() != 0) fail_now("drain_timeout");
    endtask

    // ------------------------------------------------------------------------
    // Stimulus sequence
    // ------------------------------------------------------------------------
    initial begin : p_main
        beat_t b;
        int    rd0;
        int    cyc0;
        int    t;

        aresetn       = 1'b0;
        s_axis_tvalid = 1'b1;
        {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser} = '1;

        // Reset held for 3 cycles with upstream valid asserted
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_pkt_count", pkt_count, 0);
        s_axis_tvalid = 1'b0;
        aresetn       = 1'b1;
        tick();

        // Store-and-forward: 4-beat packet, held back until its TLAST lands
        set_sink(1);
        for (int i = 0; i < 4; i++) begin
            b.data = DW'(8'h11 * (i + 1));
            b.keep = '1;
            b.last = (i == 3);
            b.id   = IW'(3);
            b.dest = DSW'(5);
            b.user = $urandom;
            send_beat(b);
            if (i < 3) chk("sf_hold_tvalid", m_axis_tvalid, 1'b0);
        end
        chk("sf_tvalid_after_last", m_axis_tvalid, 1'b1);
        chk("sf_pkt_count_1", pkt_count, 1);
        wait_drain(50);
        tick();
        chk("sf_pkt_count_0", pkt_count, 0);

        // Backpressure: 3 x 5-beat packets then one beat of a 4th packet
        set_sink(0);
        rd0 = n_rd;
        for (int p = 0; p < 3; p++) send_pkt(5, p + 1, p + 8, 0, 1'b1);
        chk("bp_level_15", level, 15);
        chk("bp_pkts_3", pkt_count, 3);
        send_pkt(1, 4, 12, 0, 1'b0);
        chk("bp_level_16", level, 16);
        chk("bp_s_tready_0", s_axis_tready, 1'b0);
        chk("bp_pkts_still_3", pkt_count, 3);
        fork
            send_pkt(5, 4, 12, 0, 1'b1);
            set_sink(1);
        join
        wait_drain(200);
        chk("bp_beats_out", n_rd - rd0, 21);

        // Oversize: 40-beat packet, sink released once the FIFO has filled
        set_sink(0);
        rd0 = n_rd;
        chk("ovf_before", oversize_count, 0);
        fork
            send_pkt(40, 6, 2, 0, 1'b1);
            begin
                t = 0;
                while ((model_q.size() != DEPTH) && (t < 500)) begin
                    tick();
                    t++;
                end
                if (model_q.size() != DEPTH) fail_now("ovf_fill_timeout");
                tick();
                set_sink(1);
            end
        join
        wait_drain(300);
        chk("ovf_count_1", oversize_count, 1);
        chk("ovf_beats_out", n_rd - rd0, 40);

        // Back-to-back single-beat packets at full rate on both sides
        cyc0 = cycle;
        for (int i = 0; i < 30; i++) begin
            send_pkt(1, i % 16, 1, 0, 1'b1);
            chk("stream_level_1", level, 1);
            chk("stream_pkts_1", pkt_count, 1);
        end
        chk("stream_cycles", cycle - cyc0, 30);
        wait_drain(50);

        // Reset in the middle of a partially stored packet
        send_pkt(3, 9, 9, 0, 1'b0);
        chk("mid_level_3", level, 3);
        chk("mid_tvalid_0", m_axis_tvalid, 1'b0);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_pkts", pkt_count, 0);
        repeat (5) tick();
        send_pkt(2, 10, 3, 0, 1'b1);
        wait_drain(50);

        // Randomised traffic with random backpressure and gaps
        set_sink(2);
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 7) == 0) send_pkt($urandom_range(17, 40), p % 16, p % 16, 1, 1'b1);
            else                           send_pkt($urandom_range(1, 12), p % 16, p % 16, 2, 1'b1);
        end
        wait_drain(4000);
        repeat (3) tick();
        chk("final_empty", model_q.size(), 0);
        chk("final_level", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : p_watchdog
        #1000000;
        n_err++;
        $display("FAIL watchdog: actual=running required=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
